// File: rtl/operand_stream_unit.sv
// operand_stream_unit: double-buffered, multi-lane activation streamer.
// A vector is captured from one of several sources through a load handshake
// and streamed LANES elements per beat through an output handshake. A shadow
// buffer holds the next vector so consecutive vectors stream without a bubble.
module operand_stream_unit #(
    parameter int COUNT              = 128,
    parameter int DATA_WIDTH         = 16,
    parameter int NEURON_INPUT_LAYER = 10,
    parameter int LANES              = 2,
    parameter int LW                 = $clog2(COUNT + 1),
    parameter int IW                 = $clog2(COUNT)
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic [1:0]                         src_sel,
    input  logic [DATA_WIDTH*NEURON_INPUT_LAYER-1:0] nn_input,
    input  logic [DATA_WIDTH*COUNT-1:0]        layer_output,
    input  logic [DATA_WIDTH*COUNT-1:0]        int_op_mem_data_out,
    input  logic                               load_valid,
    input  logic [LW-1:0]                      load_len,
    output logic                               load_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*LANES-1:0]        out_data,
    output logic [LANES-1:0]                   out_mask,
    output logic [IW-1:0]                      out_idx,
    output logic                               out_last,
    input  logic                               flush,
    output logic                               busy
);

    // EMPTY: nothing held; STREAM: active only; PEND: active plus shadow.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        STREAM = 2'b01,
        PEND   = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] act_mem [COUNT];
    logic [DATA_WIDTH-1:0] sh_mem  [COUNT];
    logic [LW-1:0]         act_len;
    logic [LW-1:0]         sh_len;
    logic [IW-1:0]         act_idx;

    logic                  act_valid;
    logic                  sh_valid;
    logic                  beat_fire;
    logic                  last_fire;
    logic                  load_fire;
    logic                  load_act;
    logic                  load_sh;
    logic                  promote;
    logic [DATA_WIDTH*COUNT-1:0] sel_vec;
    logic [LW-1:0]         len_eff;
    logic [LW:0]           lane_pos [LANES];

    assign act_valid  = (state_q != EMPTY);
    assign sh_valid   = (state_q == PEND);
    assign busy       = act_valid || sh_valid;
    assign load_ready = !sh_valid && !rst_b;
    assign load_fire  = load_valid && load_ready;
    assign out_valid  = act_valid;
    assign out_idx    = act_idx;
    // Compare one bit wider than the length so idx+LANES cannot wrap at COUNT.
    assign out_last   = act_valid &&
                        (((LW+1)'(act_idx) + (LW+1)'(LANES)) >= (LW+1)'(act_len));
    assign beat_fire  = act_valid && out_ready;
    assign last_fire  = beat_fire && out_last;

    // Zero length and anything beyond COUNT both mean a full vector.
    assign len_eff = ((load_len == '0) || (load_len > LW'(COUNT))) ? LW'(COUNT) : load_len;

    // Source mux; the network input is zero-extended up to COUNT elements.
    always_comb begin
        case (src_sel)
            2'b00:   sel_vec = (DATA_WIDTH*COUNT)'(nn_input);
            2'b01:   sel_vec = layer_output;
            2'b10:   sel_vec = int_op_mem_data_out;
            default: sel_vec = '0;
        endcase
    end

    // Next-state and buffer-move decode; flush overrides any load or beat.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d  = state_q;
        load_act = 1'b0;
        load_sh  = 1'b0;
        promote  = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_fire) begin
                        state_d  = STREAM;
                        load_act = 1'b1;
                    end
                end
                STREAM: begin
                    if (last_fire) begin
                        if (load_fire) load_act = 1'b1;
                        else           state_d  = EMPTY;
                    end else if (load_fire) begin
                        state_d = PEND;
                        load_sh = 1'b1;
                    end
                end
                PEND: begin
                    if (last_fire) begin
                        state_d = STREAM;
                        promote = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_b) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Element index and vector lengths.
    always_ff @(posedge clk) begin
        if (rst_b || flush) begin
            act_idx <= '0;
            act_len <= '0;
            sh_len  <= '0;
        end else begin
            if (load_act || last_fire) act_idx <= '0;
            else if (beat_fire)        act_idx <= act_idx + IW'(LANES);
            if (load_act)              act_len <= len_eff;
            else if (promote)          act_len <= sh_len;
            if (load_sh)               sh_len  <= len_eff;
        end
    end

    // Vector storage: capture into active or shadow, or promote shadow.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; lanes are masked to zero whenever the buffer is not valid.
        for (int i = 0; i < COUNT; i++) begin
            if (load_act)     act_mem[i] <= sel_vec[i*DATA_WIDTH +: DATA_WIDTH];
            else if (promote) act_mem[i] <= sh_mem[i];
            if (load_sh)      sh_mem[i]  <= sel_vec[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lane extraction; lanes past the vector length drive zero.
    always_comb begin
        out_data = '0;
        out_mask = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_pos[j] = (LW+1)'(act_idx) + (LW+1)'(j);
            if (act_valid && (lane_pos[j] < (LW+1)'(act_len))) begin
                out_mask[j] = 1'b1;
                out_data[j*DATA_WIDTH +: DATA_WIDTH] = act_mem[act_idx + IW'(j)];
            end
        end
    end

endmodule

// File: tb/tb_operand_stream_unit.sv
// Directed testbench for operand_stream_unit with hand-computed expectations.
module tb_operand_stream_unit;

    localparam int COUNT = 128;
    localparam int DW    = 16;
    localparam int NIL   = 10;
    localparam int LANES = 2;
    localparam int LW    = $clog2(COUNT + 1);
    localparam int IW    = $clog2(COUNT);
    localparam int BW    = 2 + LANES + IW + DW*LANES;

    typedef logic [BW-1:0] beat_t;

    logic                   clk = 1'b0;
    logic                   rst_b = 1'b1;
    logic [1:0]             src_sel = 2'b00;
    logic [DW*NIL-1:0]      nn_input = '0;
    logic [DW*COUNT-1:0]    layer_output = '0;
    logic [DW*COUNT-1:0]    int_op_mem_data_out = '0;
    logic                   load_valid = 1'b0;
    logic [LW-1:0]          load_len = '0;
    logic                   load_ready;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [DW*LANES-1:0]    out_data;
    logic [LANES-1:0]       out_mask;
    logic [IW-1:0]          out_idx;
    logic                   out_last;
    logic                   flush = 1'b0;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    beat_t obs;
    assign obs = {out_valid, out_last, out_mask, out_idx, out_data};

    always #5 clk = ~clk;

    operand_stream_unit #(
        .COUNT(COUNT), .DATA_WIDTH(DW), .NEURON_INPUT_LAYER(NIL), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_b(rst_b), .src_sel(src_sel), .nn_input(nn_input),
        .layer_output(layer_output), .int_op_mem_data_out(int_op_mem_data_out),
        .load_valid(load_valid), .load_len(load_len), .load_ready(load_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_idx(out_idx), .out_last(out_last),
        .flush(flush), .busy(busy)
    );

    // Source contents: nn_input A0+i, layer_output 1000+i, int_op 2000+i, src 3 zero.
    function automatic logic [DW-1:0] elem_val(input int src, input int i);
        case (src)
            0:       return (i < NIL) ? DW'(32'h00A0 + i) : '0;
            1:       return DW'(32'h1000 + i);
            2:       return DW'(32'h2000 + i);
            default: return '0;
        endcase
    endfunction

    // Expected {valid, last, mask, idx, data} for a beat at element idx.
    function automatic beat_t exp_beat(input int src, input int len, input int idx);
        logic [DW*LANES-1:0] d;
        logic [LANES-1:0]    m;
        d = '0;
        m = '0;
        for (int j = 0; j < LANES; j++) begin
            if (idx + j < len) begin
                m[j] = 1'b1;
                d[j*DW +: DW] = elem_val(src, idx + j);
            end
        end
        return {1'b1, (idx + LANES >= len), m, IW'(idx), d};
    endfunction

    task automatic start_load(input int src, input int len);
        src_sel    = 2'(src);
        load_len   = LW'(len);
        load_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL post_reset_load_ready: got %b expected 1", load_ready); end
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL post_reset_outputs: got %h expected 0", obs); end
    endtask

    task automatic test_full_vector();
        out_ready = 1'b1;
        start_load(1, 0);
        @(negedge clk);
        load_valid = 1'b0;
        for (int b = 0; b < 64; b++) begin
            checks++;
            if (obs !== exp_beat(1, 128, 2*b)) begin
                failures++;
                $display("FAIL full_beat%0d: got %h expected %h", b, obs, exp_beat(1, 128, 2*b));
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL full_idle: got %h expected 0", obs); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL full_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short_vector();
        out_ready = 1'b1;
        start_load(0, 5);
        @(negedge clk);
        load_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (obs !== exp_beat(0, 5, 2*b)) begin
                failures++;
                $display("FAIL short_beat%0d: got %h expected %h", b, obs, exp_beat(0, 5, 2*b));
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL short_idle: got %h expected 0", obs); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start_load(1, 4);
        @(negedge clk);
        checks++;
        if (obs !== exp_beat(1, 4, 0)) begin failures++; $display("FAIL b2b_a0: got %h expected %h", obs, exp_beat(1, 4, 0)); end
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_stream: got %b expected 1", load_ready); end
        start_load(2, 4);
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (obs !== exp_beat(1, 4, 2)) begin failures++; $display("FAIL b2b_a2: got %h expected %h", obs, exp_beat(1, 4, 2)); end
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_pend: got %b expected 0", load_ready); end
        @(negedge clk);
        checks++;
        if (obs !== exp_beat(2, 4, 0)) begin failures++; $display("FAIL b2b_b0: got %h expected %h", obs, exp_beat(2, 4, 0)); end
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_promoted: got %b expected 1", load_ready); end
        @(negedge clk);
        checks++;
        if (obs !== exp_beat(2, 4, 2)) begin failures++; $display("FAIL b2b_b2: got %h expected %h", obs, exp_beat(2, 4, 2)); end
        @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL b2b_idle: got %h expected 0", obs); end
    endtask

    task automatic test_load_on_last();
        out_ready = 1'b1;
        start_load(3, 2);
        @(negedge clk);
        checks++;
        if (obs !== exp_beat(3, 2, 0)) begin failures++; $display("FAIL lol_first: got %h expected %h", obs, exp_beat(3, 2, 0)); end
        start_load(1, 3);
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (obs !== exp_beat(1, 3, 0)) begin failures++; $display("FAIL lol_second0: got %h expected %h", obs, exp_beat(1, 3, 0)); end
        @(negedge clk);
        checks++;
        if (obs !== exp_beat(1, 3, 2)) begin failures++; $display("FAIL lol_second2: got %h expected %h", obs, exp_beat(1, 3, 2)); end
        @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL lol_idle: got %h expected 0", obs); end
    endtask

    task automatic test_backpressure();
        int pat [6] = '{1, 0, 0, 1, 1, 1};
        int exp_idx = 0;
        out_ready = 1'b0;
        start_load(1, 8);
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs !== exp_beat(1, 8, exp_idx)) begin
                failures++;
                $display("FAIL bp_cycle%0d: got %h expected %h", c, obs, exp_beat(1, 8, exp_idx));
            end
            out_ready = pat[c][0];
            @(negedge clk);
            if (pat[c] != 0) exp_idx += 2;
        end
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL bp_idle: got %h expected 0", obs); end
        out_ready = 1'b1;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        start_load(1, 0);
        @(negedge clk);
        start_load(2, 0);
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL flush_pend_ready: got %b expected 0", load_ready); end
        repeat (9) @(negedge clk);
        checks++;
        if (obs !== exp_beat(1, 128, 20)) begin failures++; $display("FAIL flush_beat10: got %h expected %h", obs, exp_beat(1, 128, 20)); end
        flush = 1'b1;
        start_load(3, 4);
        @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL flush_outputs: got %h expected 0", obs); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", load_ready); end
        @(negedge clk);
        flush = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL flush_load_dropped: got %h expected 0", obs); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_load_dropped_busy: got %b expected 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_clamp_and_reset();
        out_ready = 1'b1;
        start_load(2, 200);
        @(negedge clk);
        load_valid = 1'b0;
        for (int b = 0; b < 64; b++) begin
            checks++;
            if (obs !== exp_beat(2, 128, 2*b)) begin
                failures++;
                $display("FAIL clamp_beat%0d: got %h expected %h", b, obs, exp_beat(2, 128, 2*b));
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL clamp_idle: got %h expected 0", obs); end
        start_load(1, 200);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (obs !== exp_beat(1, 128, 10)) begin failures++; $display("FAIL midreset_before: got %h expected %h", obs, exp_beat(1, 128, 10)); end
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL midreset_outputs: got %h expected 0", obs); end
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_status: got busy=%b load_ready=%b expected 0 0", busy, load_ready);
        end
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release: got %h ready=%b expected 0 ready=1", obs, load_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NIL; i++)   nn_input[i*DW +: DW] = DW'(32'h00A0 + i);
        for (int i = 0; i < COUNT; i++) begin
            layer_output[i*DW +: DW]        = DW'(32'h1000 + i);
            int_op_mem_data_out[i*DW +: DW] = DW'(32'h2000 + i);
        end
        test_reset();
        test_full_vector();
        test_short_vector();
        test_back_to_back();
        test_load_on_last();
        test_backpressure();
        test_flush();
        test_clamp_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_stream_unit.md
# operand_stream_unit

Double-buffered, multi-lane successor to the single-lane PISO operand path feeding the compute unit. Captures a selected activation vector (network input, quantized layer output, or intermediate-output memory word) with a valid/ready load handshake and streams it out LANES elements per beat with a valid/ready output handshake. A ping-pong shadow buffer accepts the next vector while the current one streams, so back-to-back vectors have no bubble. Variable vector length supports layers narrower than COUNT.

## Interface
- COUNT, 128, max elements per vector
- DATA_WIDTH, 16, element width
- NEURON_INPUT_LAYER, 10, elements in nn_input; must be <= COUNT
- LANES, 2, elements per output beat; must divide COUNT; 1 gives legacy single-element broadcast
- LW, $clog2(COUNT+1), load_len width (derived)
- IW, $clog2(COUNT), index width (derived)

- clk  in  1  clock; all state on rising edge
- rst_b  in  1  synchronous, active-high reset (name kept from codebase; polarity is high)
- src_sel  in  2  00 nn_input zero-extended to COUNT, 01 layer_output, 10 int_op_mem_data_out, 11 all-zero vector
- nn_input  in  DATA_WIDTH*NEURON_INPUT_LAYER  network input vector
- layer_output  in  DATA_WIDTH*COUNT  quantized compute-unit output
- int_op_mem_data_out  in  DATA_WIDTH*COUNT  intermediate-output memory word
- load_valid  in  1  request to capture selected vector
- load_len  in  LW  valid elements, 1..COUNT; 0 means COUNT; values >COUNT clamp to COUNT
- load_ready  out  1  capture possible this cycle
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH*LANES  lane j = element out_idx+j (element 0 at LSBs)
- out_mask  out  LANES  lane j valid (out_idx+j < len)
- out_idx  out  IW  element index of lane 0
- out_last  out  1  final beat of vector
- flush  in  1  discard both buffers
- busy  out  1  either buffer holds data

## Operation
- Storage: active buffer (data, len, idx, valid) and shadow buffer (data, len, valid). Element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- States from (active.valid, shadow.valid): EMPTY (0,0), STREAM (1,0), PEND (1,1). (0,1) unreachable.
- load_ready = !shadow.valid && !rst_b. Load fires on load_valid && load_ready.
- Load fire, target: active if active empty or being vacated this cycle (last beat fires); otherwise shadow. Captured: selected source, clamped len; idx=0.
- Beat fire = out_valid && out_ready: idx += LANES. If out_last, active retires; shadow (if valid) promotes into active same edge with idx=0, shadow.valid=0.
- out_valid = active.valid. out_last = (idx+LANES >= len). Beats per vector = ceil(len/LANES).
- Masked lanes (out_mask bit 0) drive zero on out_data.
- While out_valid && !out_ready, all out_* held stable.
- flush: highest priority; next edge both valid bits clear, idx=0; a load or beat in the same cycle is dropped.
- busy = active.valid || shadow.valid.
- Width: idx compare done at LW+1 bits to avoid overflow at COUNT.

## Timing
- Reset: out_valid=0, out_data=0, out_mask=0, out_idx=0, out_last=0, busy=0, load_ready=0 during reset, 1 first cycle after.
- Load-to-first-beat latency: 1 cycle (load fires edge N, out_valid high after edge N).
- Throughput: 1 beat/cycle with out_ready high; back-to-back vectors with no idle cycle when shadow filled before last beat.
- Load firing same cycle as last beat with shadow empty: goes to active, out_valid stays high, out_idx=0 next cycle.
- Load and promotion same cycle impossible (load_ready=0 when shadow full).
- Reset or flush mid-stream: outputs return to reset values next edge; no partial vector resumes.

## Test plan
- LANES=2, src 01, len 0, out_ready=1 -> 64 beats, out_idx 0,2,..,126, out_last only on idx 126, elements in order.
- LANES=2, src 00, len 5 -> 3 beats; beat 3 out_idx=4, out_mask=2'b01, lane 1 data=0, out_last=1.
- Two loads back-to-back (second while first streams, len 4 each) -> 4 consecutive beats, no out_valid gap, load_ready=0 while PEND, 1 after promotion.
- out_ready toggling 1,0,0,1 -> out_data/out_idx frozen during low cycles; no beat lost or duplicated.
- flush at beat 10 with shadow full -> next cycle out_valid=0, busy=0, load_ready=1; simultaneous load ignored.
- load_len=200 with COUNT=128 -> clamped, 64 beats; rst_b high mid-stream -> all outputs zero next edge.
